// File: rtl/fetch_seq.sv
// Instruction-fetch sequencer: samples the PC, reads memory, latches the word into
// the instruction register, pulses incPC and hands the instruction to control.
module fetch_seq #(
    parameter int ADDR_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              run,
    input  logic              flush,
    input  logic [31:0]       pc_q,
    output logic              incPC,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [31:0]       mem_data,
    output logic [31:0]       ir,
    output logic              ir_valid,
    input  logic              ir_ack,
    output logic              busy,
    output logic [CNT_W-1:0]  fetch_cnt,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_REQ  = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_flush_pend;
    logic               r_inc;
    logic [ADDR_W-1:0]  r_mem_addr;
    logic [31:0]        r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_unused_pc;

    // Upper PC bits do not take part in addressing; the address wraps modulo 2^ADDR_W.
    assign w_unused_pc = ^pc_q[31:ADDR_W];

    // Handshake: ir_valid stays high for all of HOLD and ir is stable meanwhile;
    // the instruction is transferred (and counted) on any cycle with ir_valid && ir_ack.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state      <= S_IDLE;
            r_flush_pend <= 1'b0;
            r_inc        <= 1'b0;
            r_mem_addr   <= '0;
            r_ir         <= '0;
            r_cnt        <= '0;
        end else begin
            r_inc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (run && !flush) r_state <= S_ADDR;
                end
                S_ADDR: begin
                    r_mem_addr <= pc_q[ADDR_W-1:0];
                    r_state    <= flush ? S_IDLE : S_REQ;
                end
                S_REQ: begin
                    // A flush never abandons an outstanding read; it only discards its data.
                    if (mem_ready) begin
                        if (r_flush_pend || flush) begin
                            r_flush_pend <= 1'b0;
                            r_state      <= S_IDLE;
                        end else begin
                            r_ir    <= mem_data;
                            r_inc   <= 1'b1;
                            r_state <= S_HOLD;
                        end
                    end else if (flush) begin
                        r_flush_pend <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (ir_ack) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_state <= (run && !flush) ? S_ADDR : S_IDLE;
                    end else if (flush) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign incPC     = r_inc;
    assign mem_rd    = (r_state == S_REQ);
    assign mem_addr  = r_mem_addr;
    assign ir        = r_ir;
    assign ir_valid  = (r_state == S_HOLD);
    assign busy      = (r_state != S_IDLE);
    assign fetch_cnt = r_cnt;
    assign dbg_state = r_state;

endmodule
